// File: rtl/icache_fetch_arbiter.sv
// icache_fetch_arbiter: round-robin arbiter and miss sequencer sharing one icache lookup and one refill port between demand and prefetch.
module icache_fetch_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  input  logic [31:0]      req_addr0,
  input  logic [31:0]      req_addr1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_instr,
  output logic [31:0]      resp_addr,
  output logic [31:0]      cache_addr,
  input  logic             cache_hit,
  input  logic [31:0]      cache_instr,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic owner_q, owner_d, rr_last_q, rr_last_d, drop_q, drop_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic grant, drop_now;
  assign resp_instr   = data_q;
  assign resp_addr    = addr_q;
  assign cache_addr   = addr_q;
  assign mem_req_addr = addr_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
  always_comb begin
    grant         = &req_valid ? ~rr_last_q : req_valid[1];
    drop_now      = drop_q | flush;
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    drop_d        = drop_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    req_ready     = '0;
    resp_valid    = '0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: if (|req_valid && !flush) begin
        req_ready[grant] = 1'b1;
        addr_d           = grant ? req_addr1 : req_addr0;
        owner_d          = grant;
        state_d          = LOOKUP;
      end
      LOOKUP: if (flush) begin
        state_d = IDLE;
      end else if (cache_hit) begin
        data_d    = cache_instr;
        hit_cnt_d = hit_cnt_q + CNT_W'(!(&hit_cnt_q));
        rr_last_d = owner_q;
        state_d   = RESP;
      end else begin
        miss_cnt_d = miss_cnt_q + CNT_W'(!(&miss_cnt_q));
        state_d    = MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        // once the request has issued its beat must be drained even if flushed
        if (mem_req_ready) begin
          drop_d  = flush;
          state_d = MISS_WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      MISS_WAIT: begin
        drop_d = drop_now;
        if (mem_resp_valid) begin
          drop_d    = 1'b0;
          state_d   = drop_now ? IDLE : RESP;
          data_d    = drop_now ? data_q : mem_resp_data;
          rr_last_d = drop_now ? rr_last_q : owner_q;
        end
      end
      RESP: begin
        resp_valid[owner_q] = !flush;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      drop_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      drop_q     <= drop_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: doc/icache_fetch_arbiter.md
# icache_fetch_arbiter

Sequencer and arbiter in front of the instruction-cache lookup. It shares one combinational lookup port and one refill memory port between two requesters: port 0 for demand fetch and port 1 for prefetch. Each accepted request gets a lookup, is refilled from memory on a miss, and is returned to its owner as a one-cycle response pulse. The block also keeps saturating hit and miss counters.

## Interface
- CNT_W, 16, width of the hit and miss performance counters
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  aborts the in-flight request and suppresses its response
- req_valid  in  2  request valid, one bit per port
- req_addr0  in  32  port 0 fetch address
- req_addr1  in  32  port 1 fetch address
- req_ready  out  2  request accepted; at most one bit set
- resp_valid  out  2  one-hot response pulse to the owning port
- resp_instr  out  32  returned instruction word
- resp_addr  out  32  address of the returned instruction
- cache_addr  out  32  lookup address, driven with addr_q
- cache_hit  in  1  lookup hit, combinational from cache_addr
- cache_instr  in  32  lookup data, valid when cache_hit=1
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  refill request accepted
- mem_req_addr  out  32  refill address (addr_q)
- mem_resp_valid  in  1  refill data valid; one beat per request
- mem_resp_data  in  32  refill instruction
- hit_cnt  out  CNT_W  lookups that hit, saturating
- miss_cnt  out  CNT_W  lookups that missed, saturating

## Operation
- There is one outstanding request at a time. FSM states are IDLE, LOOKUP, MISS_REQ, MISS_WAIT and RESP.
- **IDLE:**
  - req_ready[g] is high for the granted port g when req_valid is nonzero and flush=0.
  - On the handshake, addr_q and owner_q are captured; next state is LOOKUP.
- **Arbitration:**
  - If only one port is valid, it is granted.
  - If both are valid, the grant goes to the port not equal to rr_last.
  - rr_last updates to owner_q when RESP is entered; its reset value is 1, so port 0 wins the first tie.
- **LOOKUP:**
  - cache_hit=1: latch cache_instr, increment hit_cnt, go to RESP.
  - cache_hit=0: increment miss_cnt, go to MISS_REQ.
- **MISS_REQ:** mem_req_valid=1 with a stable mem_req_addr until mem_req_ready, then go to MISS_WAIT.
- **MISS_WAIT:** on mem_resp_valid, latch mem_resp_data and go to RESP.
- **RESP:** resp_valid[owner_q]=1 for exactly one cycle with resp_instr and resp_addr, then go to IDLE. Requesters must accept the pulse; there is no backpressure.
- **Counters:** both saturate at 2^CNT_W-1 and do not wrap.
- **Flush:**
  - In IDLE: no grant is given.
  - In LOOKUP or RESP: go to IDLE; no resp_valid and no counter update.
  - In MISS_REQ with mem_req_ready=0: go to IDLE and drop the request.
  - In MISS_REQ with mem_req_ready=1 in the same cycle: the request has issued; go to MISS_WAIT with drop_q=1.
  - In MISS_WAIT: set drop_q=1 and remain until mem_resp_valid, then go to IDLE with no response. The refill beat is always drained.
- **Reset mid-operation:** all state clears. An outstanding memory beat arriving after reset is ignored, because IDLE ignores mem_resp_valid.

## Timing
- **Reset values:**
  - req_ready=0, resp_valid=0, resp_instr=0, resp_addr=0, mem_req_valid=0.
  - mem_req_addr=0, cache_addr=0, hit_cnt=0, miss_cnt=0.
  - State IDLE, rr_last=1, drop_q=0.
- **Hit latency:** handshake in cycle T, LOOKUP in T+1, resp_valid in T+2. The next handshake is possible in T+3.
- **Miss latency:** handshake in T, LOOKUP in T+1, mem_req_valid from T+2. With mem_req_ready at T+2 and mem_resp_valid at T+k, resp_valid is at T+k+1.
- **Outputs:** req_ready and mem_req_valid are combinational from state and inputs. resp_* are registered state outputs.
- **Memory interface:** mem_resp_valid outside MISS_WAIT is ignored.

## Test plan
- **Single hit:** port 0 requests 0x8000_0004; cache returns hit with 0xffff8001. Expect resp_valid=2'b01, resp_instr=0xffff8001 and resp_addr=0x8000_0004 at T+2; hit_cnt=1.
- **Miss refill:** port 1 requests 0x7000_0000; cache misses; mem_req_ready is given 2 cycles late and mem_resp_data=0xffff7000 arrives 3 cycles later. Expect mem_req_addr=0x7000_0000, resp_valid=2'b10, resp_instr=0xffff7000, miss_cnt=1.
- **Round-robin:** both ports hold valid for 4 requests, all hits. Expect grant order 0,1,0,1 and no back-to-back grant to the same port.
- **Flush in MISS_WAIT:** assert flush while waiting; the memory beat arrives 2 cycles later. Expect no resp_valid, FSM back in IDLE, and the next request served normally.
- **Flush on MISS_REQ handshake:** flush and mem_req_ready in the same cycle. Expect the beat drained, no response, and no second mem_req_valid.
- **Saturation:** CNT_W=2 with 5 hits. Expect hit_cnt=3; reset mid-MISS_WAIT returns all outputs to their reset values.
